// File: rtl/kart_pkg.sv
// ----------------------------------------------------------------------------
// kart_pkg
//   Shared types and constants for the kart receive decoder.
//   - KART_MAGIC      : header nibble every valid game word must carry
//   - kart_word_t     : layout of the 32-bit game word as it arrives
//   - kart_upd_t      : decoded update held in the FIFO and presented downstream
//   - kart_is_stale() : sequence-window test against the last accepted word
// ----------------------------------------------------------------------------
package kart_pkg;

    localparam logic [3:0] KART_MAGIC = 4'hA;

    localparam int MAGIC_W = 4;
    localparam int SEQ_W   = 4;
    localparam int X_W     = 12;
    localparam int Y_W     = 10;
    localparam int FLAG_W  = 2;

    localparam int FLAG_LSB  = 0;
    localparam int Y_LSB     = FLAG_LSB + FLAG_W;
    localparam int X_LSB     = Y_LSB + Y_W;
    localparam int SEQ_LSB   = X_LSB + X_W;
    localparam int MAGIC_LSB = SEQ_LSB + SEQ_W;

    typedef struct packed {
        logic [MAGIC_W-1:0] magic;
        logic [SEQ_W-1:0]   seq;
        logic [X_W-1:0]     x;
        logic [Y_W-1:0]     y;
        logic [FLAG_W-1:0]  flags;
    } kart_word_t;

    typedef struct packed {
        logic [SEQ_W-1:0]  seq;
        logic [X_W-1:0]    x;
        logic [Y_W-1:0]    y;
        logic [FLAG_W-1:0] flags;
    } kart_upd_t;

    // A word is stale when its distance from the last accepted sequence,
    // taken modulo 16, is zero (duplicate) or lands in the upper half (old).
    function automatic logic kart_is_stale(input logic            have_last,
                                           input logic [SEQ_W-1:0] last_seq,
                                           input logic [SEQ_W-1:0] seq);
        logic [SEQ_W-1:0] d;
        d = seq - last_seq;
        return have_last && ((d == '0) || d[SEQ_W-1]);
    endfunction

endpackage

// File: rtl/kart_rx_fifo.sv
// ----------------------------------------------------------------------------
// kart_rx_fifo
//   Synchronous FIFO of kart_upd_t with a registered head.
//   Ports:
//     i_clk, i_rst_n      clock, synchronous active-low reset
//     i_push, i_push_data write one entry (caller guarantees room, or a pop)
//     i_pop               remove head entry (ignored unless o_head_valid)
//     o_full              occupancy == DEPTH
//     o_head_valid        head register holds a live entry
//     o_head_data         current head entry
//   An entry written at edge E appears in the head register at edge E+1.
// ----------------------------------------------------------------------------
module kart_rx_fifo
    import kart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    input  logic      i_push,
    input  kart_upd_t i_push_data,
    input  logic      i_pop,
    output logic      o_full,
    output logic      o_head_valid,
    output kart_upd_t o_head_data
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    kart_upd_t       r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_head_vld;
    kart_upd_t       r_head;

    logic            w_pop;
    logic [AW-1:0]   w_rd_next;
    logic [CW-1:0]   w_avail;

    assign w_pop     = i_pop & r_head_vld;
    assign w_rd_next = w_pop ? (r_rd_ptr + AW'(1)) : r_rd_ptr;
    // Entries that were already stored before this edge's write; the head
    // only ever loads from these, which gives the one-cycle head latency.
    assign w_avail   = r_count - {{AW{1'b0}}, w_pop};

    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_head_vld <= 1'b0;
            r_head     <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_rd_ptr   <= w_rd_next;
            r_count    <= w_avail + {{AW{1'b0}}, i_push};
            r_head_vld <= (w_avail != '0);
            if (w_avail != '0) begin
                r_head <= r_mem[w_rd_next];
            end
        end
    end

    assign o_full       = (r_count == CW'(DEPTH));
    assign o_head_valid = r_head_vld;
    assign o_head_data  = r_head;

endmodule

// File: rtl/kart_rx_decode.sv
// ----------------------------------------------------------------------------
// kart_rx_decode
//   Validates one 32-bit game word per accepted frame, tracks the sequence
//   number, queues decoded kart updates and hands them out on valid/ready.
//   Ports:
//     eth_refclk, eth_rstn   clock, synchronous active-low reset
//     axiiv, axiid           input word pulse and data (no backpressure)
//     m_valid, m_ready       output handshake
//     m_x, m_y, m_flags, m_seq  presented update
//     cnt_good, cnt_bad_magic, cnt_stale, cnt_overflow  saturating counters
//   Build option KART_RX_PARITY_EN: axiid[0] is even parity over the word;
//   failures count in cnt_bad_magic and m_flags[0] is driven 0.
// ----------------------------------------------------------------------------
module kart_rx_decode
    import kart_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             eth_refclk,
    input  logic             eth_rstn,
    input  logic             axiiv,
    input  logic [31:0]      axiid,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [11:0]      m_x,
    output logic [9:0]       m_y,
    output logic [1:0]       m_flags,
    output logic [3:0]       m_seq,
    output logic [CNT_W-1:0] cnt_good,
    output logic [CNT_W-1:0] cnt_bad_magic,
    output logic [CNT_W-1:0] cnt_stale,
    output logic [CNT_W-1:0] cnt_overflow
);

    logic             r_s1_vld;
    kart_word_t       r_s1_word;
    logic             r_have_last;
    logic [SEQ_W-1:0] r_last_seq;
    logic [CNT_W-1:0] r_cnt_good;
    logic [CNT_W-1:0] r_cnt_bad;
    logic [CNT_W-1:0] r_cnt_stale;
    logic [CNT_W-1:0] r_cnt_ovf;

    logic             w_full;
    logic             w_head_vld;
    kart_upd_t        w_head;
    logic             w_pop;
    logic             w_bad;
    logic             w_stale;
    logic             w_ovf;
    logic             w_push;
    kart_upd_t        w_upd;

    assign w_pop = w_head_vld & m_ready;

`ifdef KART_RX_PARITY_EN
    assign w_bad = (r_s1_word.magic != KART_MAGIC) || (^r_s1_word);
`else
    assign w_bad = (r_s1_word.magic != KART_MAGIC);
`endif

    // Priority: integrity, then sequence window, then room in the FIFO.
    assign w_stale = kart_is_stale(r_have_last, r_last_seq, r_s1_word.seq);
    assign w_ovf   = w_full & ~w_pop;
    assign w_push  = r_s1_vld & ~w_bad & ~w_stale & ~w_ovf;

    always_comb begin
        w_upd.seq   = r_s1_word.seq;
        w_upd.x     = r_s1_word.x;
        w_upd.y     = r_s1_word.y;
`ifdef KART_RX_PARITY_EN
        w_upd.flags = {r_s1_word.flags[1], 1'b0};
`else
        w_upd.flags = r_s1_word.flags;
`endif
    end

    always_ff @(posedge eth_refclk) begin
        if (!eth_rstn) begin
            r_s1_vld    <= 1'b0;
            r_s1_word   <= '0;
            r_have_last <= 1'b0;
            r_last_seq  <= '0;
            r_cnt_good  <= '0;
            r_cnt_bad   <= '0;
            r_cnt_stale <= '0;
            r_cnt_ovf   <= '0;
        end else begin
            r_s1_vld <= axiiv;
            if (axiiv) begin
                r_s1_word <= kart_word_t'(axiid);
            end

            if (r_s1_vld) begin
                if (w_bad) begin
                    if (r_cnt_bad != '1) r_cnt_bad <= r_cnt_bad + CNT_W'(1);
                end else if (w_stale) begin
                    if (r_cnt_stale != '1) r_cnt_stale <= r_cnt_stale + CNT_W'(1);
                end else if (w_ovf) begin
                    if (r_cnt_ovf != '1) r_cnt_ovf <= r_cnt_ovf + CNT_W'(1);
                end else begin
                    if (r_cnt_good != '1) r_cnt_good <= r_cnt_good + CNT_W'(1);
                end
            end

            // Only accepted words move the window; dropped ones leave it alone.
            if (w_push) begin
                r_have_last <= 1'b1;
                r_last_seq  <= r_s1_word.seq;
            end
        end
    end

    kart_rx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk        (eth_refclk),
        .i_rst_n      (eth_rstn),
        .i_push       (w_push),
        .i_push_data  (w_upd),
        .i_pop        (w_pop),
        .o_full       (w_full),
        .o_head_valid (w_head_vld),
        .o_head_data  (w_head)
    );

    assign m_valid       = w_head_vld;
    assign m_x           = w_head.x;
    assign m_y           = w_head.y;
    assign m_flags       = w_head.flags;
    assign m_seq         = w_head.seq;
    assign cnt_good      = r_cnt_good;
    assign cnt_bad_magic = r_cnt_bad;
    assign cnt_stale     = r_cnt_stale;
    assign cnt_overflow  = r_cnt_ovf;

endmodule

// File: tb/tb_kart_rx_decode.sv
module tb_kart_rx_decode;

    logic        clk;
    logic        rst_n;
    logic        axiiv;
    logic [31:0] axiid;
    logic        m_valid;
    logic        m_ready;
    logic [11:0] m_x;
    logic [9:0]  m_y;
    logic [1:0]  m_flags;
    logic [3:0]  m_seq;
    logic [15:0] cnt_good;
    logic [15:0] cnt_bad_magic;
    logic [15:0] cnt_stale;
    logic [15:0] cnt_overflow;

    kart_rx_decode #(.DEPTH(4), .CNT_W(16)) dut (
        .eth_refclk    (clk),
        .eth_rstn      (rst_n),
        .axiiv         (axiiv),
        .axiid         (axiid),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_x           (m_x),
        .m_y           (m_y),
        .m_flags       (m_flags),
        .m_seq         (m_seq),
        .cnt_good      (cnt_good),
        .cnt_bad_magic (cnt_bad_magic),
        .cnt_stale     (cnt_stale),
        .cnt_overflow  (cnt_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  seq;
        logic [11:0] x;
        logic [9:0]  y;
        logic [1:0]  f;
    } rec_t;

    typedef struct {
        logic [31:0] word;
        bit          exp_push;
        logic [1:0]  exp_flags;
        int          good;
        int          bad;
        int          stale;
        int          ovf;
    } vec_t;

    rec_t q[$];
    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready)
            q.push_back('{seq: m_seq, x: m_x, y: m_y, f: m_flags});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_counts(input string tag, input int g, input int b, input int s, input int o);
        check({tag, " cnt_good"},      32'(cnt_good),      32'(g));
        check({tag, " cnt_bad_magic"}, 32'(cnt_bad_magic), 32'(b));
        check({tag, " cnt_stale"},     32'(cnt_stale),     32'(s));
        check({tag, " cnt_overflow"},  32'(cnt_overflow),  32'(o));
    endtask

    task automatic expect_pop(input string tag, input logic [31:0] w, input logic [1:0] f);
        rec_t r;
        total++;
        if (q.size() == 0) begin
            bad++;
            $display("FAIL %s pop: got no update expected seq 0x%0h", tag, w[27:24]);
        end else begin
            r = q.pop_front();
            check({tag, " seq"},   32'(r.seq), 32'(w[27:24]));
            check({tag, " x"},     32'(r.x),   32'(w[23:12]));
            check({tag, " y"},     32'(r.y),   32'(w[11:2]));
            check({tag, " flags"}, 32'(r.f),   32'(f));
        end
    endtask

    task automatic send(input logic [31:0] w);
        axiiv = 1'b1;
        axiid = w;
        @(posedge clk); #1;
        axiiv = 1'b0;
    endtask

    function automatic logic [31:0] mkword(input logic [3:0] s);
        return {4'hA, s, 12'h0A5, 10'h155, 2'b10};
    endfunction

    task automatic run_vectors();
        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            send(vecs[i].word);
            repeat (4) @(posedge clk);
            @(negedge clk);
            check_counts(tag, vecs[i].good, vecs[i].bad, vecs[i].stale, vecs[i].ovf);
            if (vecs[i].exp_push) expect_pop(tag, vecs[i].word, vecs[i].exp_flags);
            else check({tag, " no update"}, 32'(q.size()), 32'd0);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        axiiv   = 1'b0;
        axiid   = '0;
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset m_valid", 32'(m_valid), 32'd0);
        check("reset m_x",     32'(m_x),     32'd0);
        check("reset m_y",     32'(m_y),     32'd0);
        check("reset m_flags", 32'(m_flags), 32'd0);
        check("reset m_seq",   32'(m_seq),   32'd0);
        check_counts("reset", 0, 0, 0, 0);
        @(posedge clk); #1;

`ifdef KART_RX_PARITY_EN
        vecs.push_back('{32'hA0123454, 1'b1, 2'b00, 1, 0, 0, 0});
        vecs.push_back('{32'hA4123457, 1'b0, 2'b00, 1, 1, 0, 0});
        vecs.push_back('{32'hA1123455, 1'b1, 2'b00, 2, 1, 0, 0});
        run_vectors();
`else
        vecs.push_back('{32'hA0123454, 1'b1, 2'b00, 1, 0, 0, 0});
        vecs.push_back('{32'hA1123454, 1'b1, 2'b00, 2, 0, 0, 0});
        vecs.push_back('{32'hA2123454, 1'b1, 2'b00, 3, 0, 0, 0});
        vecs.push_back('{32'hA3123454, 1'b1, 2'b00, 4, 0, 0, 0});
        vecs.push_back('{32'hA3123454, 1'b0, 2'b00, 4, 0, 1, 0});
        vecs.push_back('{32'hA1123454, 1'b0, 2'b00, 4, 0, 2, 0});
        vecs.push_back('{32'h54123454, 1'b0, 2'b00, 4, 1, 2, 0});
        vecs.push_back('{32'hA4123457, 1'b1, 2'b11, 5, 1, 2, 0});
        vecs.push_back('{32'hAC123454, 1'b0, 2'b00, 5, 1, 3, 0});
        vecs.push_back('{32'hAB123454, 1'b1, 2'b00, 6, 1, 3, 0});
        run_vectors();

        // Overflow: six back-to-back words into a stalled FIFO of four.
        m_ready = 1'b0;
        begin
            logic [3:0] seqs [6];
            seqs = '{4'hC, 4'hD, 4'hE, 4'hF, 4'h0, 4'h1};
            for (int i = 0; i < 6; i++) begin
                axiiv = 1'b1;
                axiid = mkword(seqs[i]);
                @(posedge clk); #1;
            end
            axiiv = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_counts("ovf", 10, 1, 3, 2);
        check("ovf m_valid", 32'(m_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall m_seq stable", 32'(m_seq), 32'hC);
            check("stall m_x stable",   32'(m_x),   32'h0A5);
        end
        @(posedge clk); #1 m_ready = 1'b1;
        repeat (7) @(posedge clk);
        #1 m_ready = 1'b0;
        for (int i = 0; i < 4; i++) expect_pop("drain", mkword(4'(4'hC + i)), 2'b10);
        check("drain count", 32'(q.size()), 32'd0);

        // Full FIFO with a push landing on the same edge as a pop.
        for (int i = 2; i <= 5; i++) send(mkword(4'(i)));
        repeat (4) @(posedge clk); #1;
        axiiv = 1'b1;
        axiid = mkword(4'h6);
        @(posedge clk); #1;
        axiiv   = 1'b0;
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_counts("coincide", 15, 1, 3, 2);
        @(posedge clk); #1 m_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1 m_ready = 1'b0;
        for (int i = 2; i <= 6; i++) expect_pop("coincide", mkword(4'(i)), 2'b10);
        check("coincide count", 32'(q.size()), 32'd0);

        // Reset mid-operation: FIFO holding data, word in the check stage.
        send(mkword(4'h7));
        repeat (4) @(posedge clk); #1;
        axiiv = 1'b1;
        axiid = mkword(4'h8);
        @(posedge clk); #1;
        axiiv = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midrst m_valid", 32'(m_valid), 32'd0);
        check_counts("midrst", 0, 0, 0, 0);
        q.delete();
        @(posedge clk); #1 m_ready = 1'b1;
        // seq 3 would be stale against the pre-reset window; it must be accepted now.
        send(mkword(4'h3));
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_counts("postrst", 1, 0, 0, 0);
        expect_pop("postrst", mkword(4'h3), 2'b10);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
